// File: rtl/scrambler_pkg.sv
// Shared definitions for the serial additive scrambler.
//   LEN_W          default width of the frame length / bit counter
//   SEED           LFSR value loaded at reset and at every frame start (nonzero)
//   TAP_HI/TAP_LO  LFSR state bits that form the feedback (x^7 + x^4 + 1)
//   state_t        frame control states
package scrambler_pkg;
  localparam int         LEN_W  = 12;
  localparam logic [6:0] SEED   = 7'h7F;
  localparam int         TAP_HI = 6;
  localparam int         TAP_LO = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/scrambler_lfsr.sv
// 7-bit Fibonacci LFSR, polynomial x^7 + x^4 + 1.
// The key bit is the feedback of the current state, so the very first key
// after a load is already a function of SEED (0 for SEED = 7'h7F).
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low reset (loads SEED)
//   load   in   reload SEED (has priority over step)
//   step   in   advance one position
//   key    out  current key bit
module scrambler_lfsr #(
  parameter logic [6:0] SEED = scrambler_pkg::SEED
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  output logic key
);
  import scrambler_pkg::*;

  logic [6:0] lfsr_p0;

  assign key = lfsr_p0[TAP_HI] ^ lfsr_p0[TAP_LO];

  // LFSR state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_p0 <= SEED;
    end else if (load) begin
      lfsr_p0 <= SEED;
    end else if (step) begin
      lfsr_p0 <= {lfsr_p0[5:0], key};
    end
  end
endmodule

// File: rtl/txrx_scrambler.sv
// Serial additive scrambler / descrambler, one bit per clock, one frame of
// 'length' bits per request. The same block serves as transmitter and
// receiver: an RX instance fed from TX data_out and requested one cycle
// after the TX instance undoes the scrambling.
// Optional feature: define SCRAMBLER_BYPASS_EN to add the 'bypass' input,
// which is captured at frame start and passes data through unscrambled
// (the LFSR and ready timing are unchanged).
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   data_in   in   serial input bit
//   length    in   frame length in bits, captured at frame start
//   request   in   frame start request (level); must drop before a new frame
//   bypass    in   (SCRAMBLER_BYPASS_EN only) pass data through for the frame
//   data_out  out  registered scrambled / descrambled bit
//   ready     out  high while data_out holds a valid frame bit
module txrx_scrambler #(
  parameter int         LEN_W = scrambler_pkg::LEN_W,
  parameter logic [6:0] SEED  = scrambler_pkg::SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic [LEN_W-1:0] length,
  input  logic             request,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic             bypass,
`endif
  output logic             data_out,
  output logic             ready
);
  import scrambler_pkg::*;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] count;
  logic             start;
  logic             lfsr_step;
  logic             key;
  logic             byp_q;

  scrambler_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .step  (lfsr_step),
    .key   (key)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE waits for request to drop so a held request
  // cannot start a second frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (request) state_nxt = (length == '0) ? DONE : RUN;
      RUN:  if (count <= LEN_W'(1)) state_nxt = DONE;
      DONE: if (!request) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    start     = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      IDLE:    start     = request;
      RUN:     lfsr_step = 1'b1;
      default: ;
    endcase
  end

  // Bit counter: loaded at frame start, saturating decrement while running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= length;
    end else if (state == RUN && count != '0) begin
      count <= count - LEN_W'(1);
    end
  end

`ifdef SCRAMBLER_BYPASS_EN
  // Bypass is frozen for the whole frame at frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_q <= 1'b0;
    end else if (start) begin
      byp_q <= bypass;
    end
  end
`else
  assign byp_q = 1'b0;
`endif

  // Output register: ready follows RUN by one edge, so it is high for
  // exactly 'length' cycles; data_out holds its last bit between frames.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= 1'b0;
      ready    <= 1'b0;
    end else begin
      ready <= (state == RUN);
      if (state == RUN) begin
        data_out <= data_in ^ (key & ~byp_q);
      end
    end
  end
endmodule

// File: tb/tb_txrx_scrambler.sv
// Bench for txrx_scrambler: a TX instance plus an RX instance fed from the
// TX output. Expected key bits come from the polynomial recurrence on the
// bit sequence (b[n+7] = b[n] ^ b[n+3], seeded with the SEED bits).
module tb_txrx_scrambler;
  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic        tx_req, rx_req;
  logic [11:0] tx_len, rx_len;
  logic        tx_dout, tx_rdy, rx_dout, rx_rdy;
`ifdef SCRAMBLER_BYPASS_EN
  logic        tx_byp, rx_byp;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bit keyq[$];
  bit dq[$];
  bit outq[$];

  always #5 clk = ~clk;

  txrx_scrambler u_tx (
    .clk      (clk),
    .reset    (reset),
    .data_in  (din),
    .length   (tx_len),
    .request  (tx_req),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass   (tx_byp),
`endif
    .data_out (tx_dout),
    .ready    (tx_rdy)
  );

  txrx_scrambler u_rx (
    .clk      (clk),
    .reset    (reset),
    .data_in  (tx_dout),
    .length   (rx_len),
    .request  (rx_req),
`ifdef SCRAMBLER_BYPASS_EN
    .bypass   (rx_byp),
`endif
    .data_out (rx_dout),
    .ready    (rx_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Key stream for n bits from the polynomial recurrence
  task automatic make_keys(input int n);
    bit         b[$];
    logic [6:0] sd;
    sd = 7'h7F;
    keyq.delete();
    for (int i = 0; i < 7; i++) b.push_back(sd[6-i]);
    for (int i = 0; i < n; i++) begin
      b.push_back(b[i] ^ b[i+3]);
      keyq.push_back(b[i+7]);
    end
  endtask

  task automatic fill_random(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(1'($urandom));
  endtask

  task automatic fill_zero(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(1'b0);
  endtask

  // One TX frame from IDLE; entered and left at posedge+1 with the DUT idle.
  task automatic run_frame(input int len, input bit hold, input bit byp);
    make_keys(len);
    outq.delete();
    tx_len = 12'(len);
    tx_req = 1'b1;
`ifdef SCRAMBLER_BYPASS_EN
    tx_byp = byp;
`endif
    @(posedge clk); #1;
    tx_len = 12'($urandom);
`ifdef SCRAMBLER_BYPASS_EN
    tx_byp = ~byp;
`endif
    if (!hold) tx_req = 1'b0;
    check("ready_lead", tx_rdy, 0);
    if (len > 0) din = dq[0];
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      outq.push_back(tx_dout);
      check("ready_run", tx_rdy, 1);
      check("dout", tx_dout, dq[i] ^ (byp ? 1'b0 : keyq[i]));
      if (i + 1 < len) din = dq[i+1];
      else din = 1'($urandom);
    end
    repeat (hold ? 3 : 1) begin
      @(posedge clk); #1;
      check("ready_tail", tx_rdy, 0);
    end
    tx_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  v8;
    logic [15:0] pat;
    logic [4:0]  v5;
    logic [2:0]  v3;

    reset  = 1'b0;
    din    = 1'b0;
    tx_req = 1'b0;
    rx_req = 1'b0;
    tx_len = '0;
    rx_len = '0;
`ifdef SCRAMBLER_BYPASS_EN
    tx_byp = 1'b0;
    rx_byp = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_dout", tx_dout, 0);
    check("rst_tx_rdy", tx_rdy, 0);
    check("rst_rx_rdy", rx_rdy, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // All-zero data exposes the raw key stream
    fill_zero(8);
    run_frame(8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) v8[7-i] = outq[i];
    check("t1_pattern", v8, 8'b00001110);

    // Loopback: RX requested one cycle after TX recovers the plain data
    pat    = 16'hA5C3;
    tx_len = 12'd16;
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
    din    = pat[15];
    rx_len = 12'd16;
    rx_req = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        rx_req = 1'b0;
        check("lb_rx_lead", rx_rdy, 0);
      end else begin
        check("lb_rx_rdy", rx_rdy, 1);
        check("lb_rx_dout", rx_dout, pat[17-k]);
      end
      if (k < 16) din = pat[15-k];
    end
    @(posedge clk); #1;
    check("lb_rx_tail", rx_rdy, 0);
    @(posedge clk); #1;

    // Zero-length frame, then a normal 3-bit frame
    run_frame(0, 1'b1, 1'b0);
    fill_random(3);
    run_frame(3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) v3[2-i] = outq[i];
    check("t3_frame", v3, {dq[0] ^ 1'b0, dq[1] ^ 1'b0, dq[2] ^ 1'b0});

    // Asynchronous reset in the middle of a 10-bit frame
    tx_len = 12'd10;
    tx_req = 1'b1;
    din    = 1'b0;
    @(posedge clk); #1;
    tx_req = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("t4_pre_rdy", tx_rdy, 1);
    check("t4_pre_dout", tx_dout, 1);
    reset = 1'b0;
    #1;
    check("t4_rst_dout", tx_dout, 0);
    check("t4_rst_rdy", tx_rdy, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    fill_zero(5);
    run_frame(5, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) v5[4-i] = outq[i];
    check("t4_restart", v5, 5'b00001);

    // Request held high across the end of a frame, then a fresh frame
    fill_random(4);
    run_frame(4, 1'b1, 1'b0);
    fill_random(4);
    run_frame(4, 1'b0, 1'b0);

`ifdef SCRAMBLER_BYPASS_EN
    dq.delete();
    dq.push_back(1'b1); dq.push_back(1'b0); dq.push_back(1'b1); dq.push_back(1'b1);
    run_frame(4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) v5[3-i] = outq[i];
    check("t6_bypass", v5[3:0], 4'b1011);
`endif

    // Random frames
    for (int f = 0; f < 8; f++) begin
      int len;
      bit byp;
      len = int'($urandom_range(1, 40));
      byp = 1'b0;
`ifdef SCRAMBLER_BYPASS_EN
      byp = 1'($urandom);
`endif
      fill_random(len);
      run_frame(len, 1'($urandom), byp);
    end

    // Maximum length frame
    fill_random(4095);
    run_frame(4095, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
